probe_scan: RTL and testbench
=============================

PROBE_SCAN -- requirements
Module: probe_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1: system-clock cycles per serial-clock half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1: single-cycle request to begin one scan of channels 0..15.
REQ-005 SHALL have port stop  input  1: synchronous abort of the scan in progress.
REQ-006 SHALL have port auto  input  1: when high, a completed scan restarts immediately at channel 0.
REQ-007 SHALL have port sel  output  4: channel select driven to the 16:1 32-bit datapath multiplexer.
REQ-008 SHALL have port mux_out  input  32: selected word returned by that multiplexer.
REQ-009 SHALL have port sclk  output  1: serial clock to the external shift register.
REQ-010 SHALL have port sdata  output  1: serial data, MSB first.
REQ-011 SHALL have port sload  output  1: one-cycle strobe after each 32-bit word is fully shifted.
REQ-012 SHALL have port busy  output  1: high in every state except IDLE.
REQ-013 SHALL have port chan  output  4: index of the word currently being shifted.
REQ-014 SHALL have port done  output  1: one-cycle pulse at scan completion.

Function
REQ-015 SHALL implement states IDLE, SETTLE, CAPTURE, SHIFT, LOAD, DONE.
REQ-016 IDLE: start=1 and stop=0 -> sel=0, go to SETTLE; otherwise stay in IDLE.
REQ-017 SETTLE: exactly 1 cycle with sel stable, giving the combinational mux a full cycle; then go to CAPTURE.
REQ-018 CAPTURE: 1 cycle; the 32-bit shift register loads mux_out, chan<=sel, bit counter clears to 0; then go to SHIFT.
REQ-019 SHIFT: 32 bits, each bit a low phase of CLK_DIV cycles then a high phase of CLK_DIV cycles; sclk=0 in the low phase, 1 in the high phase.
REQ-020 sdata SHALL present bit 31-n for the whole of bit n's low and high phases and change only at the start of a low phase.
REQ-021 After the high phase of bit 31, sclk SHALL return to 0 and the FSM SHALL go to LOAD.
REQ-022 LOAD: sload=1 for exactly 1 cycle; if sel=15 go to DONE, else sel<=sel+1 and go to SETTLE.
REQ-023 DONE: done=1 for exactly 1 cycle; auto=1 -> sel<=0, go to SETTLE; else go to IDLE.
REQ-024 Per-channel latency SHALL be exactly 3+64*CLK_DIV cycles (SETTLE+CAPTURE+SHIFT+LOAD); full scan 16*(3+64*CLK_DIV)+1 cycles from leaving IDLE to the end of DONE.
REQ-025 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-026 stop=1 in any non-IDLE state SHALL force IDLE on the next edge with sclk=0, sload=0, done=0, sel held; no done pulse.
REQ-027 start and stop high together in IDLE: stop SHALL win; remain IDLE.
REQ-028 auto deasserted mid-scan SHALL let the current scan finish; the FSM then returns to IDLE after DONE.
REQ-029 sel SHALL change only on LOAD exit, DONE exit, or IDLE->SETTLE; it SHALL never wrap 15->0 except via DONE or IDLE.
REQ-030 The phase counter SHALL be at least 8 bits wide; CLK_DIV=0 is illegal and SHALL NOT be handled.
REQ-031 mux_out SHALL be sampled only in CAPTURE; changes in mux_out at any other time SHALL NOT affect sdata.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, sel=0, chan=0, sclk=0, sdata=0, sload=0, busy=0, done=0, shift register 0 and counters 0, regardless of clk.
REQ-033 Reset asserted mid-SHIFT SHALL abort the scan with no sload or done pulse; after release the block stays in IDLE until start.

Verification
REQ-034 CLK_DIV=1, mux model returns 32'hA5000000|sel, single start -> 16 words shifted MSB first, sload count 16, done exactly 1073 cycles after start is sampled, busy low next cycle.
REQ-035 CLK_DIV=3, channel 0 = 32'h80000001 -> sdata=1 for the first 6 cycles of SHIFT, bit 31 rising sclk at cycle 4 of SHIFT, final bit 1, sload 195 cycles after SETTLE entry.
REQ-036 auto=1 held -> done pulses every 1073 cycles (CLK_DIV=1) with sel returning to 0 the cycle after done; auto dropped during scan 2 -> IDLE after its done.
REQ-037 stop pulsed during channel 7 SHIFT -> next cycle busy=0, sclk=0, sel=7, no done; subsequent start restarts at sel=0.
REQ-038 rst asserted asynchronously mid-bit while sclk=1 -> sclk, busy, sel go to 0 before the next clk edge; start+stop together in IDLE -> busy stays 0.

Source files
------------

// File: rtl/probe_scan.sv
// Scans 16 words from an external 32-bit mux and shifts each one out MSB first on a divided serial clock.
// A load strobe follows each word. A done pulse follows channel 15. Auto mode restarts the scan at channel 0.
module probe_scan #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        auto,
  output logic [3:0]  sel,
  input  logic [31:0] mux_out,
  output logic        sclk,
  output logic        sdata,
  output logic        sload,
  output logic        busy,
  output logic [3:0]  chan,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  chan_q, chan_d;
  logic [31:0] shreg_q, shreg_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        phase_q, phase_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;

  logic half_end;
  logic bit_end;
  logic word_end;
  logic abort;

  assign half_end = (div_cnt_q == DIV_LAST);
  assign bit_end  = half_end & phase_q;
  assign word_end = bit_end & (bit_cnt_q == 5'd31);
  assign abort    = stop & (state_q != S_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an abort beats every other transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start && !stop) state_d = S_SETTLE;
        S_SETTLE:  state_d = S_CAPTURE;
        S_CAPTURE: state_d = S_SHIFT;
        S_SHIFT:   if (word_end) state_d = S_LOAD;
        S_LOAD:    state_d = (sel_q == 4'd15) ? S_DONE : S_SETTLE;
        S_DONE:    state_d = auto ? S_SETTLE : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy  = (state_q != S_IDLE);
    sclk  = (state_q == S_SHIFT) & phase_q;
    sdata = (state_q == S_SHIFT) & shreg_q[31];
    sload = (state_q == S_LOAD);
    done  = (state_q == S_DONE);
    sel   = sel_q;
    chan  = chan_q;
  end

  // Datapath next-state: channel select, capture register and bit timing
  always_comb begin
    sel_d     = sel_q;
    chan_d    = chan_q;
    shreg_d   = shreg_q;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) sel_d = 4'd0;
      end
      S_CAPTURE: begin
        shreg_d   = mux_out;
        chan_d    = sel_q;
        div_cnt_d = 8'd0;
        phase_d   = 1'b0;
        bit_cnt_d = 5'd0;
      end
      S_SHIFT: begin
        if (half_end) begin
          div_cnt_d = 8'd0;
          phase_d   = ~phase_q;
          // Advance to the next bit only at the end of a high phase
          if (phase_q) begin
            shreg_d   = {shreg_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_LOAD: begin
        if (sel_q != 4'd15) sel_d = sel_q + 4'd1;
      end
      S_DONE: begin
        if (auto) sel_d = 4'd0;
      end
      default: ;
    endcase
    if (abort) begin
      sel_d     = sel_q;
      div_cnt_d = 8'd0;
      phase_d   = 1'b0;
      bit_cnt_d = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 4'd0;
      chan_q    <= 4'd0;
      shreg_q   <= 32'd0;
      div_cnt_q <= 8'd0;
      phase_q   <= 1'b0;
      bit_cnt_q <= 5'd0;
    end else begin
      sel_q     <= sel_d;
      chan_q    <= chan_d;
      shreg_q   <= shreg_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_probe_scan.sv
// Directed bench for probe_scan: one instance at CLK_DIV=1, one at CLK_DIV=3, each fed by a small mux model.
module tb_probe_scan;

  logic        clk;
  logic        rst;

  logic        start1, stop1, auto1;
  logic [3:0]  sel1, chan1;
  logic [31:0] mux1;
  logic        sclk1, sdata1, sload1, busy1, done1;

  logic        start3, stop3, auto3;
  logic [3:0]  sel3, chan3;
  logic [31:0] mux3;
  logic        sclk3, sdata3, sload3, busy3, done3;
  logic [31:0] noise3;

  int total;
  int bad;

  assign mux1 = 32'hA500_0000 | {28'h0, sel1};
  assign mux3 = ((sel3 == 4'd0) ? 32'h8000_0001 : {sel3, 28'h0C0FFEE}) ^ noise3;

  probe_scan #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .auto(auto1),
    .sel(sel1), .mux_out(mux1), .sclk(sclk1), .sdata(sdata1), .sload(sload1),
    .busy(busy1), .chan(chan1), .done(done1)
  );

  probe_scan #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .stop(stop3), .auto(auto3),
    .sel(sel3), .mux_out(mux3), .sclk(sclk3), .sdata(sdata3), .sload(sload3),
    .busy(busy3), .chan(chan3), .done(done3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cyc, nload, ndone, done_at, expch, ones, viol, first_hi, load_at, d1, d2;
  logic [31:0] word;
  logic prev_sclk, prev_sdata;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    start1 = 0; stop1 = 0; auto1 = 0;
    start3 = 0; stop3 = 0; auto3 = 0;
    noise3 = 32'h0;
    #12;
    check_val("rst_busy",  32'(busy1),  0);
    check_val("rst_sel",   32'(sel1),   0);
    check_val("rst_chan",  32'(chan1),  0);
    check_val("rst_sclk",  32'(sclk1),  0);
    check_val("rst_sdata", 32'(sdata1), 0);
    check_val("rst_sload", 32'(sload1), 0);
    check_val("rst_done",  32'(done1),  0);
    rst = 1'b0;
    tick();

    // start and stop together in IDLE: stop wins
    start1 = 1; stop1 = 1; start3 = 1; stop3 = 1;
    tick();
    start1 = 0; stop1 = 0; start3 = 0; stop3 = 0;
    check_val("ss_busy1", 32'(busy1), 0);
    check_val("ss_busy3", 32'(busy3), 0);
    tick();
    check_val("ss_busy1_later", 32'(busy1), 0);

    // Full single scan at CLK_DIV=1, with a start pulse mid-scan that must be ignored
    start1 = 1; tick(); start1 = 0;
    cyc = 1; nload = 0; ndone = 0; done_at = 0; expch = 0; word = 0;
    while (busy1 && cyc < 1200) begin
      if (sclk1) word = {word[30:0], sdata1};
      if (sload1) begin
        check_val("word", word, 32'hA500_0000 | 32'(expch));
        check_val("chan", 32'(chan1), 32'(expch));
        $display("scan1 ch=%0d word=%h", chan1, word);
        nload++;
        expch++;
      end
      if (done1) begin
        ndone++;
        done_at = cyc;
      end
      start1 = (cyc == 500);
      tick();
      cyc++;
    end
    start1 = 0;
    check_val("scan_cycles", 32'(cyc - 1), 1073);
    check_val("done_at", 32'(done_at), 1073);
    check_val("nload", 32'(nload), 16);
    check_val("ndone", 32'(ndone), 1);
    check_val("busy_after", 32'(busy1), 0);
    tick();
    check_val("no_queue", 32'(busy1), 0);

    // CLK_DIV=3, channel 0 = 80000001; mux corrupted after CAPTURE must not matter
    start3 = 1; tick(); start3 = 0;
    cyc = 1; ones = 0; viol = 0; first_hi = 0; load_at = 0; word = 0;
    prev_sclk = 0; prev_sdata = 0;
    while (load_at == 0 && cyc < 400) begin
      if (cyc >= 3 && cyc <= 8 && sdata3) ones++;
      if (cyc == 9) check_val("div3_bit30", 32'(sdata3), 0);
      if (sclk3 && !prev_sclk) begin
        word = {word[30:0], sdata3};
        if (first_hi == 0) first_hi = cyc;
      end
      if (cyc >= 4 && cyc <= 194 && sdata3 !== prev_sdata && !(prev_sclk && !sclk3)) viol++;
      if (sload3) load_at = cyc;
      if (cyc == 3) noise3 = 32'hFFFF_FFFF;
      prev_sclk = sclk3;
      prev_sdata = sdata3;
      if (load_at == 0) begin
        tick();
        cyc++;
      end
    end
    $display("scan3 ch=%0d word=%h load_at=%0d", chan3, word, load_at);
    check_val("div3_first6_ones", 32'(ones), 6);
    check_val("div3_first_rise", 32'(first_hi - 2), 4);
    check_val("div3_sload_at", 32'(load_at), 195);
    check_val("div3_word", word, 32'h8000_0001);
    check_val("div3_last_bit", 32'(word[0]), 1);
    check_val("div3_sdata_stable", 32'(viol), 0);
    tick();
    check_val("div3_next_sel", 32'(sel3), 1);
    stop3 = 1; tick(); stop3 = 0;
    noise3 = 32'h0;
    check_val("div3_stop_busy", 32'(busy3), 0);
    check_val("div3_stop_sel", 32'(sel3), 1);

    // Auto mode: two scans, auto dropped during the second
    auto1 = 1; start1 = 1; tick(); start1 = 0;
    cyc = 1; ndone = 0; d1 = 0; d2 = 0;
    while (cyc < 2400) begin
      if (d1 != 0 && cyc == d1 + 1) begin
        check_val("auto_sel0", 32'(sel1), 0);
        check_val("auto_busy", 32'(busy1), 1);
      end
      if (d1 != 0 && cyc == d1 + 100) auto1 = 0;
      if (done1) begin
        ndone++;
        if (d1 == 0) d1 = cyc;
        else d2 = cyc;
      end
      if (!busy1) break;
      tick();
      cyc++;
    end
    auto1 = 0;
    $display("auto done1=%0d done2=%0d", d1, d2);
    check_val("auto_first", 32'(d1), 1073);
    check_val("auto_period", 32'(d2 - d1), 1073);
    check_val("auto_ndone", 32'(ndone), 2);
    check_val("auto_idle", 32'(busy1), 0);
    check_val("auto_idle_at", 32'(cyc), 32'(d2 + 1));

    // Stop during channel 7 SHIFT
    start1 = 1; tick(); start1 = 0;
    cyc = 0;
    while (!(sel1 == 4'd7 && sclk1) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_val("reach_ch7", 32'(sel1), 7);
    stop1 = 1; tick(); stop1 = 0;
    $display("stop sel=%0d busy=%0d", sel1, busy1);
    check_val("stop_busy", 32'(busy1), 0);
    check_val("stop_sclk", 32'(sclk1), 0);
    check_val("stop_sel", 32'(sel1), 7);
    check_val("stop_done", 32'(done1), 0);
    ndone = 0;
    repeat (5) begin
      tick();
      if (done1) ndone++;
    end
    check_val("stop_nodone", 32'(ndone), 0);
    check_val("stop_stays_idle", 32'(busy1), 0);
    start1 = 1; tick(); start1 = 0;
    check_val("restart_sel", 32'(sel1), 0);
    check_val("restart_busy", 32'(busy1), 1);

    // Asynchronous reset mid-bit while sclk is high
    cyc = 0;
    while (!(sel1 == 4'd3 && sclk1) && cyc < 1000) begin
      tick();
      cyc++;
    end
    check_val("reach_ch3", 32'(sel1), 3);
    #2 rst = 1'b1;
    #1;
    $display("async rst sclk=%0d busy=%0d sel=%0d", sclk1, busy1, sel1);
    check_val("arst_sclk",  32'(sclk1),  0);
    check_val("arst_busy",  32'(busy1),  0);
    check_val("arst_sel",   32'(sel1),   0);
    check_val("arst_chan",  32'(chan1),  0);
    check_val("arst_sload", 32'(sload1), 0);
    check_val("arst_done",  32'(done1),  0);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (4) begin
      tick();
      if (done1 || sload1) ndone++;
    end
    check_val("arst_stays_idle", 32'(busy1), 0);
    check_val("arst_no_pulses", 32'(ndone), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
